// File: rtl/gba_sound_pkg.sv
// Shared definitions for the GBA/DMG sound channel controllers (ch1..ch4).
package gba_sound_pkg;

   localparam int         FS_STEPS = 8;
   localparam logic [6:0] LEN_MAX  = 7'd64;
   localparam logic [3:0] VOL_MAX  = 4'd15;

   // Channel activity state; the encoding doubles as the NR52 status bit.
   typedef enum logic {
      CH_OFF = 1'b0,
      CH_ON  = 1'b1
   } chan_state_t;

   // One envelope step, saturating at 0 and VOL_MAX instead of wrapping.
   function automatic logic [3:0] env_step(input logic [3:0] vol, input logic up);
      logic [3:0] res;
      res = vol;
      if (up) begin
         if (vol != VOL_MAX) res = vol + 4'd1;
      end else begin
         if (vol != 4'd0) res = vol - 4'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/frame_sequencer.sv
// 512 Hz frame sequencer: divides the system clock down to an 8-step
// sequence and emits the length and envelope clock ticks.
module frame_sequencer
   import gba_sound_pkg::*;
#(
   parameter int FS_DIV = 32768
) (
   input  logic       system_clock,
   input  logic       reset,
   output logic [2:0] fs_step,
   output logic       len_tick,
   output logic       env_tick
);

   localparam int               DIV_W    = (FS_DIV > 2) ? $clog2(FS_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FS_DIV - 1);
   localparam logic [2:0]       STEP_LAST = 3'(FS_STEPS - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       step_q, step_d;
   logic             fs_tick;

   // Divider wrap produces fs_tick; ticks are decoded from the step being entered.
   always_comb begin
      fs_tick  = (div_q == DIV_LAST);
      div_d    = fs_tick ? '0 : div_q + DIV_W'(1);
      step_d   = step_q;
      if (fs_tick) begin
         step_d = (step_q == STEP_LAST) ? 3'd0 : step_q + 3'd1;
      end
      len_tick = fs_tick && !step_d[0];
      env_tick = fs_tick && (step_d == 3'd7);
   end

   // Divider and step registers.
   always_ff @(posedge system_clock) begin
      if (reset) begin
         div_q  <= '0;
         step_q <= 3'd0;
      end else begin
         div_q  <= div_d;
         step_q <= step_d;
      end
   end

   assign fs_step = step_q;

endmodule

// File: rtl/square_channel_ctrl.sv
// Per-channel controller for square channels ch1/ch2: length counter,
// volume envelope, trigger handling and output gating of the duty wave.
module square_channel_ctrl
   import gba_sound_pkg::*;
#(
   parameter int FS_DIV = 32768
) (
   input  logic       system_clock,
   input  logic       reset,
   input  logic [7:0] NRx1,
   input  logic [7:0] NRx2,
   input  logic [7:0] NRx4,
   input  logic       nrx1_wr,
   input  logic       nrx4_wr,
   input  logic [3:0] wave_in,
   output logic       channel_on,
   output logic [3:0] volume,
   output logic [3:0] sample_out,
   output logic [2:0] fs_step
);

   logic        len_tick, env_tick;
   logic        trigger, dac_on, len_en, len_expire;
   logic [6:0]  length_q, length_d;
   logic [3:0]  volume_q, volume_d;
   logic [2:0]  env_timer_q, env_timer_d;
   chan_state_t state_q, state_d;

   // Duty bits, the register's low NRx4 bits and the upper wave bits belong to other blocks.
   logic unused_inputs;
   assign unused_inputs = ^{NRx1[7:6], NRx4[5:0], wave_in[3:1]};

   frame_sequencer #(.FS_DIV(FS_DIV)) u_fs (
      .system_clock (system_clock),
      .reset        (reset),
      .fs_step      (fs_step),
      .len_tick     (len_tick),
      .env_tick     (env_tick)
   );

   // Decode register strobes and live control bits.
   always_comb begin
      trigger = nrx4_wr && NRx4[7];
      dac_on  = |NRx2[7:3];
      len_en  = NRx4[6];
   end

   // Length counter: an NRx1 write wins, then a trigger (which suppresses the
   // decrement and refills an empty counter), then the len_tick decrement.
   always_comb begin
      length_d   = length_q;
      len_expire = 1'b0;
      if (nrx1_wr) begin
         length_d = LEN_MAX - {1'b0, NRx1[5:0]};
      end else if (trigger) begin
         if (length_q == 7'd0) length_d = LEN_MAX;
      end else if (len_tick && len_en && (length_q != 7'd0)) begin
         length_d   = length_q - 7'd1;
         len_expire = (length_q == 7'd1);
      end
   end

   // Envelope: trigger reloads volume and timer; otherwise env_tick counts the
   // timer down and steps the volume each time it runs out.
   always_comb begin
      volume_d    = volume_q;
      env_timer_d = env_timer_q;
      if (trigger) begin
         volume_d    = NRx2[7:4];
         env_timer_d = NRx2[2:0];
      end else if (env_tick && (NRx2[2:0] != 3'd0)) begin
         // A timer of 0 (period changed after trigger) is treated as expired.
         if (env_timer_q <= 3'd1) begin
            env_timer_d = NRx2[2:0];
            volume_d    = env_step(volume_q, NRx2[3]);
         end else begin
            env_timer_d = env_timer_q - 3'd1;
         end
      end
   end

   // Channel FSM: DAC off dominates everything, including a trigger.
   always_comb begin
      state_d = state_q;
      case (state_q)
         CH_OFF: begin
            if (trigger && dac_on) state_d = CH_ON;
         end
         CH_ON: begin
            if (!dac_on)         state_d = CH_OFF;
            else if (len_expire) state_d = CH_OFF;
         end
         default: state_d = CH_OFF;
      endcase
   end

   // State registers.
   always_ff @(posedge system_clock) begin
      if (reset) begin
         state_q     <= CH_OFF;
         length_q    <= 7'd0;
         volume_q    <= 4'd0;
         env_timer_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         length_q    <= length_d;
         volume_q    <= volume_d;
         env_timer_q <= env_timer_d;
      end
   end

   assign channel_on = (state_q == CH_ON);
   assign volume     = volume_q;
   // Gating is combinational on registered state so the sample tracks wave_in
   // with no added cycle.
   assign sample_out = (channel_on && wave_in[0]) ? volume_q : 4'd0;

endmodule
